// File: rtl/audio_adc_rx.sv
// I2S receiver: synchronises the codec clocks, aligns to the left-frame start and
// presents each complete stereo pair on a valid/ready output with a sticky overrun flag.
module audio_adc_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  enable,
    input  logic                  adc_bclk,
    input  logic                  adc_lrck,
    input  logic                  adc_dat,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] DW_C = CW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SKIP  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic                   bclk_s, lrck_s, dat_s;
    logic                   bclk_prev, lrck_last;
    logic                   bclk_rise, lrck_chg;

    logic [DATA_WIDTH-1:0]  shreg, sh_next, store_word, left_hold;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   have_left;
    logic                   clr_word, shift_en, store, pair_done;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_last <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], adc_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], adc_lrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adc_dat};
            bclk_prev <= bclk_s;
            if (bclk_rise) lrck_last <= lrck_s;
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign lrck_chg  = bclk_rise & (lrck_s ^ lrck_last);

    assign sh_next   = {shreg[DATA_WIDTH-2:0], dat_s};
    assign cnt_next  = cnt + CW'(1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    // The rise that reveals an LRCK change still carries the LSB of the word being
    // closed (I2S one-bit delay), so SHIFT folds that bit in before storing.
    always_comb begin
        state_nxt  = state;
        clr_word   = 1'b0;
        shift_en   = 1'b0;
        store      = 1'b0;
        store_word = '0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = ALIGN;
            end
            ALIGN: begin
                if (lrck_chg && !lrck_s) state_nxt = SKIP;
            end
            SKIP: begin
                clr_word  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bclk_rise) begin
                    shift_en = 1'b1;
                    if (lrck_chg) begin
                        store      = 1'b1;
                        store_word = sh_next << (DW_C - cnt_next);
                        state_nxt  = SKIP;
                    end else if (cnt_next == DW_C) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (lrck_chg) begin
                    store      = 1'b1;
                    store_word = shreg;
                    state_nxt  = SKIP;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            clr_word  = 1'b0;
            shift_en  = 1'b0;
            store     = 1'b0;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr_word) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= sh_next;
            cnt   <= cnt_next;
        end
    end

    // lrck_last still holds the channel of the word being stored: 0 = left, 1 = right.
    assign pair_done = store & lrck_last & have_left;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            left_hold <= '0;
            have_left <= 1'b0;
        end else if (!enable) begin
            have_left <= 1'b0;
        end else if (store) begin
            if (!lrck_last) begin
                left_hold <= store_word;
                have_left <= 1'b1;
            end else begin
                have_left <= 1'b0;
            end
        end
    end

    // Handshake: a pair transfers on a cycle with out_valid & out_ready; data holds
    // while out_valid is high, and a pair finished while stalled is dropped (overrun).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            left_data  <= '0;
            right_data <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (pair_done && (!out_valid || out_ready)) begin
                left_data  <= left_hold;
                right_data <= store_word;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (pair_done && out_valid && !out_ready) overrun <= 1'b1;
            else if (overrun_clr)                     overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: true I2S waveforms into a 16-bit and a 24-bit
// instance, scoreboarded pair transfers plus direct checks of flags and stalls.
module tb_audio_adc_rx;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        adc_bclk, adc_lrck, adc_dat;

    logic        enable16, ready16, clr16;
    logic [15:0] left16, right16;
    logic        valid16, overrun16;
    logic [2:0]  state16;

    logic        enable24, ready24, clr24;
    logic [23:0] left24, right24;
    logic        valid24, overrun24;
    logic [2:0]  state24;

    logic [31:0] exp16_q[$];
    logic [47:0] exp24_q[$];
    int          checks = 0;
    int          failures = 0;
    int          extra16 = 0;
    int          extra24 = 0;
    logic        carry = 1'b0;
    time         rise_t = 0;
    time         valid_t = 0;

    always #10 clk_clk = ~clk_clk;

    audio_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) u_dut16 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable16),
        .adc_bclk(adc_bclk), .adc_lrck(adc_lrck), .adc_dat(adc_dat),
        .left_data(left16), .right_data(right16), .out_valid(valid16),
        .out_ready(ready16), .overrun(overrun16), .overrun_clr(clr16),
        .state_dbg(state16)
    );

    audio_adc_rx #(.DATA_WIDTH(24), .SYNC_STAGES(2)) u_dut24 (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable24),
        .adc_bclk(adc_bclk), .adc_lrck(adc_lrck), .adc_dat(adc_dat),
        .left_data(left24), .right_data(right24), .out_valid(valid24),
        .out_ready(ready24), .overrun(overrun24), .overrun_clr(clr24),
        .state_dbg(state24)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_clk);
        #3;
    endtask

    // Period i drives the bit chosen in period i-1, so data lags LRCK by one bit.
    task automatic send_bits(input logic lr, input logic [31:0] word, input int nbits,
                             input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            adc_bclk = 1'b0;
            adc_lrck = lr;
            adc_dat  = carry;
            #160;
            adc_bclk = 1'b1;
            rise_t   = $time;
            #160;
            if (i < nbits) carry = word[nbits-1-i];
            else           carry = 1'b0;
        end
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits, input int slot);
        send_bits(lr, word, nbits, 0, slot);
    endtask

    always @(posedge valid16) valid_t = $time;

    always @(negedge clk_clk) begin
        if (valid16 && ready16) begin
            if (exp16_q.size() == 0) extra16++;
            else check("pair16", {32'd0, left16, right16}, {32'd0, exp16_q.pop_front()});
        end
        if (valid24 && ready24) begin
            if (exp24_q.size() == 0) extra24++;
            else check("pair24", {16'd0, left24, right24}, {16'd0, exp24_q.pop_front()});
        end
    end

    initial begin
        reset_reset_n = 1'b0;
        adc_bclk = 1'b0; adc_lrck = 1'b1; adc_dat = 1'b0;
        enable16 = 1'b0; ready16 = 1'b1; clr16 = 1'b0;
        enable24 = 1'b0; ready24 = 1'b1; clr24 = 1'b0;
        #3;
        wait_clks(3);
        check("rst_left", 64'(left16), 64'h0);
        check("rst_right", 64'(right16), 64'h0);
        check("rst_valid", 64'(valid16), 64'h0);
        check("rst_overrun", 64'(overrun16), 64'h0);
        check("rst_state", 64'(state16), 64'h0);
        check("rst_valid24", 64'(valid24), 64'h0);
        reset_reset_n = 1'b1;
        wait_clks(2);

        // Basic pair with latency measurement on the closing LRCK edge
        enable16 = 1'b1;
        send_slot(1'b1, 32'h0, 16, 16);
        exp16_q.push_back(32'hA5C3_1234);
        send_slot(1'b0, 32'hA5C3, 16, 16);
        send_slot(1'b1, 32'h1234, 16, 16);
        send_bits(1'b0, 32'h0, 16, 0, 1);
        check("latency_ok", 64'((valid_t > rise_t) && (valid_t - rise_t <= 80)), 64'h1);
        send_bits(1'b0, 32'h0, 16, 1, 16);
        enable16 = 1'b0;
        wait_clks(2);
        check("valid_drop", 64'(valid16), 64'h0);

        // Enable in the middle of a right frame
        send_slot(1'b0, 32'hDEAD, 16, 16);
        send_bits(1'b1, 32'hBEEF, 16, 0, 8);
        enable16 = 1'b1;
        send_bits(1'b1, 32'hBEEF, 16, 8, 16);
        exp16_q.push_back(32'h0001_FFFF);
        send_slot(1'b0, 32'h0001, 16, 16);
        send_slot(1'b1, 32'hFFFF, 16, 16);
        send_slot(1'b0, 32'h0, 16, 16);
        enable16 = 1'b0;
        wait_clks(2);

        // Stalled consumer across three pairs
        ready16 = 1'b0;
        enable16 = 1'b1;
        send_slot(1'b1, 32'h0, 16, 16);
        send_slot(1'b0, 32'h1111, 16, 16);
        send_slot(1'b1, 32'h2222, 16, 16);
        send_slot(1'b0, 32'h3333, 16, 16);
        send_slot(1'b1, 32'h4444, 16, 16);
        send_slot(1'b0, 32'h5555, 16, 16);
        send_slot(1'b1, 32'h6666, 16, 16);
        send_slot(1'b0, 32'h0, 16, 16);
        enable16 = 1'b0;
        check("stall_valid", 64'(valid16), 64'h1);
        check("stall_left", 64'(left16), 64'h1111);
        check("stall_right", 64'(right16), 64'h2222);
        check("overrun_set", 64'(overrun16), 64'h1);
        clr16 = 1'b1;
        wait_clks(1);
        clr16 = 1'b0;
        check("overrun_clr", 64'(overrun16), 64'h0);
        exp16_q.push_back(32'h1111_2222);
        ready16 = 1'b1;
        wait_clks(3);
        check("stall_release", 64'(valid16), 64'h0);

        // Reset pulse during left SHIFT
        enable16 = 1'b1;
        send_slot(1'b1, 32'h0, 16, 16);
        send_bits(1'b0, 32'h1357, 16, 0, 6);
        reset_reset_n = 1'b0;
        #1;
        check("rst_mid_left", 64'(left16), 64'h0);
        check("rst_mid_right", 64'(right16), 64'h0);
        check("rst_mid_valid", 64'(valid16), 64'h0);
        check("rst_mid_state", 64'(state16), 64'h0);
        #39;
        reset_reset_n = 1'b1;
        send_bits(1'b0, 32'h1357, 16, 6, 16);
        send_slot(1'b1, 32'h2468, 16, 16);
        exp16_q.push_back(32'h7F00_80FF);
        send_slot(1'b0, 32'h7F00, 16, 16);
        send_slot(1'b1, 32'h80FF, 16, 16);
        send_slot(1'b0, 32'h0, 16, 16);
        enable16 = 1'b0;
        wait_clks(2);

        // Enable dropped during right SHIFT with a pair pending
        ready16 = 1'b0;
        enable16 = 1'b1;
        send_slot(1'b1, 32'h0, 16, 16);
        send_slot(1'b0, 32'h0F0F, 16, 16);
        send_slot(1'b1, 32'hF0F0, 16, 16);
        send_slot(1'b0, 32'h5A5A, 16, 16);
        send_bits(1'b1, 32'hA5A5, 16, 0, 8);
        enable16 = 1'b0;
        send_bits(1'b1, 32'hA5A5, 16, 8, 16);
        send_slot(1'b0, 32'h1212, 16, 16);
        send_slot(1'b1, 32'h3434, 16, 16);
        send_slot(1'b0, 32'h0, 16, 16);
        check("dis_valid", 64'(valid16), 64'h1);
        check("dis_left", 64'(left16), 64'h0F0F);
        check("dis_right", 64'(right16), 64'hF0F0);
        check("dis_overrun", 64'(overrun16), 64'h0);
        exp16_q.push_back(32'h0F0F_F0F0);
        ready16 = 1'b1;
        wait_clks(3);
        check("dis_release", 64'(valid16), 64'h0);
        send_slot(1'b1, 32'h5656, 16, 16);
        send_bits(1'b0, 32'h7777, 16, 0, 8);
        enable16 = 1'b1;
        send_bits(1'b0, 32'h7777, 16, 8, 16);
        send_slot(1'b1, 32'h8888, 16, 16);
        check("realign_idle", 64'(valid16), 64'h0);
        exp16_q.push_back(32'h4242_2424);
        send_slot(1'b0, 32'h4242, 16, 16);
        send_slot(1'b1, 32'h2424, 16, 16);
        send_slot(1'b0, 32'h0, 16, 16);
        enable16 = 1'b0;
        wait_clks(2);

        // 24-bit receiver with short and long frames
        enable24 = 1'b1;
        send_slot(1'b1, 32'h0, 20, 20);
        exp24_q.push_back(48'hABCDE0_123450);
        send_slot(1'b0, 32'hABCDE, 20, 20);
        send_slot(1'b1, 32'h12345, 20, 20);
        send_slot(1'b0, 32'h0, 20, 20);
        enable24 = 1'b0;
        wait_clks(2);
        enable24 = 1'b1;
        send_slot(1'b1, 32'h0, 32, 32);
        exp24_q.push_back(48'hDEADBE_012345);
        send_slot(1'b0, 32'hDEADBEEF, 32, 32);
        send_slot(1'b1, 32'h01234567, 32, 32);
        send_slot(1'b0, 32'h0, 32, 32);
        enable24 = 1'b0;
        wait_clks(4);

        check("extra16", 64'(extra16), 64'h0);
        check("missing16", 64'(exp16_q.size()), 64'h0);
        check("extra24", 64'(extra24), 64'h0);
        check("missing24", 64'(exp24_q.size()), 64'h0);
        check("overrun24", 64'(overrun24), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
